// File: rtl/sl_transmitter.sv
// Serial-line word transmitter: Le data bits LSB first, odd parity, then a stop symbol, over the SL0/SL1 pair.
// Latency: the first bit is driven on the edge that accepts send_imm; the word then occupies (Le+2)*2*P clocks.
// Backpressure: send_imm and config writes are ignored while busy. SL_TX_BUSY_STATUS_EN mirrors busy on r_config_w[6].
module sl_transmitter (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] data_a,
  input  logic        send_imm,
  input  logic [9:0]  wr_config_w,
  input  logic        wr_config_enable,
  output logic [9:0]  r_config_w,
  output logic        SL0,
  output logic        SL1,
  output logic        send_in_process
);

  typedef enum logic [1:0] {S_IDLE, S_DATA, S_PARITY, S_STOP} state_t;

  state_t      state_q, state_d;
  logic [5:0]  cfg_len_q;
  logic [2:0]  cfg_mode_q;
  logic [31:0] shift_q, shift_d;
  logic [5:0]  bits_left_q, bits_left_d;
  logic        parity_q, parity_d;
  logic        phase_q, phase_d;
  logic [5:0]  tick_q, tick_d;
  logic [2:0]  me_q, me_d;
  logic        sl0_q, sl0_d;
  logic        sl1_q, sl1_d;

  logic        cfg_wr;
  logic [5:0]  start_len_raw;
  logic [2:0]  start_mode_raw;
  logic [5:0]  start_len;
  logic [2:0]  start_me;
  logic [5:0]  tick_last;
  logic        phase_end;
  logic        par_bit;
  logic        status_bit;
  logic        unused_cfg_rsvd;

  assign unused_cfg_rsvd = wr_config_w[6];
  assign cfg_wr          = wr_config_enable && (state_q == S_IDLE);

  // A write landing on the same edge as the accepted send governs that word.
  assign start_len_raw  = wr_config_enable ? wr_config_w[5:0] : cfg_len_q;
  assign start_mode_raw = wr_config_enable ? wr_config_w[9:7] : cfg_mode_q;
  assign start_len      = (start_len_raw == 6'd0 || start_len_raw > 6'd32) ? 6'd32 : start_len_raw;
  assign start_me       = (start_mode_raw > 3'd5) ? 3'd5 : start_mode_raw;

  // P-1 as a right-shifted all-ones mask: me=0 gives 1, me=5 gives 63.
  assign tick_last = 6'h3F >> (3'd5 - me_q);
  assign phase_end = (tick_q == tick_last);
  assign par_bit   = ~(parity_q ^ shift_q[0]);

  always_comb begin
    state_d     = state_q;
    shift_d     = shift_q;
    bits_left_d = bits_left_q;
    parity_d    = parity_q;
    phase_d     = phase_q;
    tick_d      = tick_q;
    me_d        = me_q;
    sl0_d       = sl0_q;
    sl1_d       = sl1_q;
    if (state_q == S_IDLE) begin
      if (send_imm) begin
        state_d     = S_DATA;
        shift_d     = data_a;
        bits_left_d = start_len;
        me_d        = start_me;
        parity_d    = 1'b0;
        phase_d     = 1'b0;
        tick_d      = 6'd0;
        sl0_d       = data_a[0];
        sl1_d       = ~data_a[0];
      end
    end else if (!phase_end) begin
      tick_d = tick_q + 6'd1;
    end else begin
      tick_d = 6'd0;
      if (!phase_q) begin
        phase_d = 1'b1;
        sl0_d   = 1'b1;
        sl1_d   = 1'b1;
      end else begin
        phase_d = 1'b0;
        if (state_q == S_DATA) begin
          shift_d     = shift_q >> 1;
          parity_d    = parity_q ^ shift_q[0];
          bits_left_d = bits_left_q - 6'd1;
          if (bits_left_q == 6'd1) begin
            state_d = S_PARITY;
            sl0_d   = par_bit;
            sl1_d   = ~par_bit;
          end else begin
            sl0_d = shift_q[1];
            sl1_d = ~shift_q[1];
          end
        end else if (state_q == S_PARITY) begin
          state_d = S_STOP;
          sl0_d   = 1'b0;
          sl1_d   = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      shift_q     <= 32'd0;
      bits_left_q <= 6'd0;
      parity_q    <= 1'b0;
      phase_q     <= 1'b0;
      tick_q      <= 6'd0;
      me_q        <= 3'd0;
      sl0_q       <= 1'b1;
      sl1_q       <= 1'b1;
    end else begin
      state_q     <= state_d;
      shift_q     <= shift_d;
      bits_left_q <= bits_left_d;
      parity_q    <= parity_d;
      phase_q     <= phase_d;
      tick_q      <= tick_d;
      me_q        <= me_d;
      sl0_q       <= sl0_d;
      sl1_q       <= sl1_d;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cfg_len_q  <= 6'd32;
      cfg_mode_q <= 3'd0;
    end else if (cfg_wr) begin
      cfg_len_q  <= wr_config_w[5:0];
      cfg_mode_q <= wr_config_w[9:7];
    end
  end

  assign SL0             = sl0_q;
  assign SL1             = sl1_q;
  assign send_in_process = (state_q != S_IDLE);

`ifdef SL_TX_BUSY_STATUS_EN
  assign status_bit = send_in_process;
`else
  assign status_bit = 1'b0;
`endif

  assign r_config_w = {cfg_mode_q, status_bit, cfg_len_q};

endmodule

// File: tb/tb_sl_transmitter.sv
// Bench for sl_transmitter: vector table, corner sequences and random words against a waveform/receiver model.
module tb_sl_transmitter;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] data_a;
  logic        send_imm;
  logic [9:0]  wr_config_w;
  logic        wr_config_enable;
  logic [9:0]  r_config_w;
  logic        SL0, SL1, send_in_process;

  int errors = 0;
  int checks = 0;

  sl_transmitter dut (
    .clk(clk), .rst(rst), .data_a(data_a), .send_imm(send_imm),
    .wr_config_w(wr_config_w), .wr_config_enable(wr_config_enable),
    .r_config_w(r_config_w), .SL0(SL0), .SL1(SL1), .send_in_process(send_in_process)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          len;
    int          mode;
    logic [31:0] data;
    bit          same_cycle;
    int          exp_busy;
    logic [9:0]  exp_rb;
  } vec_t;

  vec_t vecs[8];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic int eff_len(input int l);
    return (l >= 1 && l <= 32) ? l : 32;
  endfunction

  function automatic int period(input int m);
    return 2 << ((m > 5) ? 5 : m);
  endfunction

  function automatic logic [31:0] len_mask(input int le);
    logic [63:0] m;
    m = (64'd1 << le) - 64'd1;
    return m[31:0];
  endfunction

  // Expected {busy, SL0, SL1} t clocks after the accepting edge.
  function automatic logic [2:0] model(input logic [31:0] d, input int le, input int p, input int t);
    int  sym;
    logic b;
    if (t >= (le + 2) * 2 * p) return 3'b011;
    if ((t % (2 * p)) >= p) return 3'b111;
    sym = t / (2 * p);
    if (sym < le) begin
      b = d[sym];
      return {1'b1, b, ~b};
    end
    if (sym == le) begin
      b = ~(^(d & len_mask(le)));
      return {1'b1, b, ~b};
    end
    return 3'b100;
  endfunction

  task automatic write_cfg(input int l, input int m);
    @(negedge clk);
    wr_config_w      = {m[2:0], 1'b0, l[5:0]};
    wr_config_enable = 1'b1;
    @(negedge clk);
    wr_config_enable = 1'b0;
  endtask

  task automatic run_word(input string tag, input logic [31:0] d, input int l, input int m,
                          input bit same_cycle, input int intr_t, input int exp_busy);
    int          le, p, n, window, busy_cnt, bad_t, nb, ones;
    logic [2:0]  exp, act, bad_act, bad_exp;
    logic [1:0]  prev, cur;
    logic [33:0] dec;
    logic [31:0] dec_data;
    bit          stop_seen;
    le = eff_len(l);
    p = period(m);
    n = (le + 2) * 2 * p;
    window = n + 4 * p + 4;
    busy_cnt = 0; bad_t = -1; nb = 0; stop_seen = 0; prev = 2'b11; dec = '0;
    bad_act = '0; bad_exp = '0;
    @(negedge clk);
    data_a   = d;
    send_imm = 1'b1;
    if (same_cycle) begin
      wr_config_w      = {m[2:0], 1'b0, l[5:0]};
      wr_config_enable = 1'b1;
    end
    @(negedge clk);
    send_imm = 1'b0;
    wr_config_enable = 1'b0;
    data_a = $urandom;
    for (int t = 0; t < window; t++) begin
      act = {send_in_process, SL0, SL1};
      exp = model(d, le, p, t);
      if (act !== exp && bad_t < 0) begin
        bad_t = t; bad_act = act; bad_exp = exp;
      end
      busy_cnt += int'(send_in_process);
      cur = {SL0, SL1};
      if (cur != 2'b11 && prev == 2'b11 && !stop_seen) begin
        if (cur == 2'b00) stop_seen = 1;
        else begin
          if (nb < 34) dec[nb] = (cur == 2'b10);
          nb++;
        end
      end
      prev = cur;
      send_imm = 1'b0;
      wr_config_enable = 1'b0;
      if (t == intr_t) begin
        data_a           = 32'h1234;
        send_imm         = 1'b1;
        wr_config_w      = {3'd0, 1'b0, 6'd8};
        wr_config_enable = 1'b1;
      end
      @(negedge clk);
    end
    checks++;
    if (bad_t >= 0) begin
      errors++;
      $display("FAIL %s wave: at t=%0d got {busy,SL0,SL1}=%b expected %b", tag, bad_t, bad_act, bad_exp);
    end
    check({tag, " busy_len"}, busy_cnt, exp_busy);
    check({tag, " stop_seen"}, {31'd0, stop_seen}, 32'd1);
    check({tag, " bit_count"}, nb - 1, le);
    dec_data = '0;
    ones = 0;
    for (int i = 0; i < nb && i < 34; i++) begin
      if (i < nb - 1 && i < 32) dec_data[i] = dec[i];
      ones += int'(dec[i]);
    end
    check({tag, " data"}, dec_data, d & len_mask(le));
    check({tag, " odd_parity"}, ones % 2, 1);
  endtask

  initial begin
    vecs[0] = '{8,  0, 32'h000000A5, 1'b0, 40,   10'h008};
    vecs[1] = '{1,  1, 32'hFFFFFFF1, 1'b0, 24,   10'h081};
    vecs[2] = '{0,  0, 32'h80000001, 1'b1, 136,  10'h000};
    vecs[3] = '{40, 2, 32'h5A5AC3C3, 1'b0, 544,  10'h128};
    vecs[4] = '{4,  6, 32'hFFFFFFF6, 1'b1, 768,  10'h304};
    vecs[5] = '{3,  7, 32'h00000005, 1'b0, 640,  10'h383};
    vecs[6] = '{32, 5, 32'hFFFFFFFF, 1'b0, 4352, 10'h2A0};
    vecs[7] = '{16, 3, 32'h00000000, 1'b1, 576,  10'h190};

    rst = 1'b1; data_a = '0; send_imm = 1'b0; wr_config_w = '0; wr_config_enable = 1'b0;
    repeat (3) @(negedge clk);
    send_imm = 1'b1;
    @(negedge clk);
    check("rst_lines", {30'd0, SL0, SL1}, 32'd3);
    check("rst_busy", {31'd0, send_in_process}, 32'd0);
    check("rst_cfg", {22'd0, r_config_w}, 32'h020);
    send_imm = 1'b0;
    rst = 1'b0;
    repeat (4) @(negedge clk);
    check("idle_lines", {30'd0, SL0, SL1}, 32'd3);
    check("idle_busy", {31'd0, send_in_process}, 32'd0);
    check("idle_cfg", {22'd0, r_config_w}, 32'h020);

    for (int i = 0; i < 8; i++) begin
      if (!vecs[i].same_cycle) write_cfg(vecs[i].len, vecs[i].mode);
      run_word($sformatf("vec%0d", i), vecs[i].data, vecs[i].len, vecs[i].mode,
               vecs[i].same_cycle, -1, vecs[i].exp_busy);
      check($sformatf("vec%0d cfg", i), {22'd0, r_config_w}, {22'd0, vecs[i].exp_rb});
    end

    // Send and config write while busy must not disturb the word or the config.
    write_cfg(16, 2);
    run_word("busy_ignore", 32'h0000BEEF, 16, 2, 1'b0, 20, 288);
    check("busy_ignore cfg", {22'd0, r_config_w}, 32'h110);

    // Asynchronous abort mid-word, then a clean word.
    write_cfg(20, 1);
    @(negedge clk);
    data_a = 32'hFFFF0F0F;
    send_imm = 1'b1;
    @(negedge clk);
    send_imm = 1'b0;
    repeat (30) @(negedge clk);
    check("abort_pre_busy", {31'd0, send_in_process}, 32'd1);
    #2 rst = 1'b1;
    #1;
    check("abort_lines", {30'd0, SL0, SL1}, 32'd3);
    check("abort_busy", {31'd0, send_in_process}, 32'd0);
    check("abort_cfg", {22'd0, r_config_w}, 32'h020);
    @(negedge clk);
    rst = 1'b0;
    repeat (2) @(negedge clk);
    check("abort_quiet", {29'd0, send_in_process, SL0, SL1}, 32'd3);
    write_cfg(8, 0);
    run_word("after_abort", 32'h00000003, 8, 0, 1'b0, -1, 40);

    for (int w = 0; w < 6; w++) begin
      int l, m;
      logic [31:0] d;
      bit same;
      l = 8 + 2 * int'($urandom_range(0, 12));
      m = int'($urandom_range(0, 5));
      d = $urandom;
      same = $urandom_range(0, 1) == 1;
      if (!same) write_cfg(l, m);
      run_word($sformatf("rnd%0d", w), d, l, m, same, -1, (l + 2) * 2 * period(m));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
